// File: rtl/alu_sched_pkg.sv
// Shared opcode, slot-state and latency definitions for the ALU dispatch scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } slot_state_t;

  localparam int LAT_ADD_DEF = 1;
  localparam int LAT_MUL_DEF = 3;

endpackage

// File: rtl/alu_exec_slot.sv
// One ALU core slot: latches an accepted op, counts down its execute latency,
// then holds the 16-bit result until the output stage drains it.
module alu_exec_slot
  import alu_sched_pkg::*;
#(
  parameter int ID_W    = 2,
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic [7:0]      a,
  input  logic [7:0]      b,
  input  logic [1:0]      op,
  input  logic [ID_W-1:0] id,
  input  logic            drain,
  output logic            idle,
  output logic            done,
  output logic [15:0]     result,
  output logic [ID_W-1:0] owner
);

  localparam int LAT_MAX = (LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  slot_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       a_p0;
  logic [7:0]       b_p0;
  logic [1:0]       op_p0;

  function automatic logic [15:0] alu_compute(input logic [7:0] x, input logic [7:0] y,
                                              input logic [1:0] opc);
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] res;
    ex = {8'h00, x};
    ey = {8'h00, y};
    case (opc)
      OP_ADD:  res = ex + ey;
      OP_SUB:  res = ex - ey;
      OP_MUL:  res = ex * ey;
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= S_EXEC;
          cnt   <= (op == OP_MUL) ? CNT_W'(LAT_MUL - 1) : CNT_W'(LAT_ADD - 1);
        end
        S_EXEC: if (cnt != '0) cnt <= cnt - 1'b1;
                else           state <= S_DONE;
        S_DONE: if (drain) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0: operands captured on accept; result formed on the last execute cycle
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept) begin
      a_p0  <= a;
      b_p0  <= b;
      op_p0 <= op;
      owner <= id;
    end
    if (state == S_EXEC && cnt == '0) result <= alu_compute(a_p0, b_p0, op_p0);
  end

  assign idle = (state == S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: rtl/alu_dispatch_sched.sv
// Round-robin request arbiter feeding NUM_CORES ALU slots, with a single
// registered valid/ready response stage draining the lowest-index finished slot.
module alu_dispatch_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CORES = 4,
  parameter int LAT_ADD   = LAT_ADD_DEF,
  parameter int LAT_MUL   = LAT_MUL_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*8-1:0]         req_a,
  input  logic [NUM_REQ*8-1:0]         req_b,
  input  logic [NUM_REQ*2-1:0]         req_op,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_result,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] rsp_core,
  output logic [NUM_CORES-1:0]         core_busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              grant_found;
  logic [7:0]        sel_a;
  logic [7:0]        sel_b;
  logic [1:0]        sel_op;

  logic [NUM_CORES-1:0] idle_vec;
  logic [NUM_CORES-1:0] done_vec;
  logic [NUM_CORES-1:0] slot_accept;
  logic [NUM_CORES-1:0] slot_drain;
  logic [15:0]          slot_result [NUM_CORES];
  logic [ID_W-1:0]      slot_owner  [NUM_CORES];

  logic              free_found;
  logic [CORE_W-1:0] free_idx;
  logic              done_found;
  logic [CORE_W-1:0] done_idx;
  logic              accept;
  logic              rsp_load;

  // Scan requesters starting at rr_ptr, wrapping at NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      if (scan_idx == ID_W'(NUM_REQ - 1)) scan_idx = '0;
      else                                scan_idx = scan_idx + 1'b1;
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a  = req_a[i*8 +: 8];
        sel_b  = req_b[i*8 +: 8];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (idle_vec[j]) begin
        free_found = 1'b1;
        free_idx   = CORE_W'(j);
      end
      if (done_vec[j]) begin
        done_found = 1'b1;
        done_idx   = CORE_W'(j);
      end
    end
  end

  assign accept   = grant_found && free_found;
  assign rsp_load = !rsp_valid || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  for (genvar j = 0; j < NUM_CORES; j++) begin : g_slot
    assign slot_accept[j] = accept && (free_idx == CORE_W'(j));
    assign slot_drain[j]  = rsp_load && done_found && (done_idx == CORE_W'(j));

    alu_exec_slot #(
      .ID_W    (ID_W),
      .LAT_ADD (LAT_ADD),
      .LAT_MUL (LAT_MUL)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .accept (slot_accept[j]),
      .a      (sel_a),
      .b      (sel_b),
      .op     (sel_op),
      .id     (grant_idx),
      .drain  (slot_drain[j]),
      .idle   (idle_vec[j]),
      .done   (done_vec[j]),
      .result (slot_result[j]),
      .owner  (slot_owner[j])
    );
  end

  assign core_busy = ~idle_vec;

  // p1: response register, refilled whenever empty or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_core   <= '0;
    end else begin
      if (accept) rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (rsp_load) begin
        rsp_valid <= done_found;
        if (done_found) begin
          rsp_result <= slot_result[done_idx];
          rsp_id     <= slot_owner[done_idx];
          rsp_core   <= done_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch_sched.sv
// Directed and randomized bench for alu_dispatch_sched against a transaction-level model.
module tb_alu_dispatch_sched;

  localparam int NR = 4;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*8-1:0] req_a;
  logic [NR*8-1:0] req_b;
  logic [NR*2-1:0] req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_result;
  logic [1:0]      rsp_id;
  logic [1:0]      rsp_core;
  logic [NC-1:0]   core_busy;

  alu_dispatch_sched #(.NUM_REQ(NR), .NUM_CORES(NC), .LAT_ADD(1), .LAT_MUL(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_core   (rsp_core),
    .core_busy  (core_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int id;
    int core;
    int res;
  } txn_t;

  txn_t          sb[$];
  bit [NC-1:0]   occ;
  int            rr;
  bit            prev_valid;
  bit            prev_ready;
  logic [15:0]   prev_res;
  logic [1:0]    prev_id;
  logic [1:0]    prev_core;
  int            rsp_cores[$];
  logic [NR-1:0] acc_vec;
  int            dut_acc_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0:       return a + b;
      1:       return (a - b + 65536) % 65536;
      2:       return a * b;
      default: return 0;
    endcase
  endfunction

  // Evaluated mid-cycle: checks outputs produced by the previous edge, predicts this edge.
  task automatic model_step();
    bit          new_rsp;
    int          k;
    int          win;
    int          fc;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [1:0]  vo;
    logic [NR-1:0] exp_rdy;
    acc_vec = req_valid & req_ready;
    if (acc_vec != '0) dut_acc_cnt++;
    if (rst) begin
      sb.delete();
      occ        = '0;
      rr         = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      acc_vec    = '0;
      return;
    end
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, prev_res);
      chk("hold_id", rsp_id, prev_id);
      chk("hold_core", rsp_core, prev_core);
    end
    new_rsp = rsp_valid && (!prev_valid || prev_ready);
    if (new_rsp) begin
      rsp_cores.push_back(int'(rsp_core));
      k = -1;
      foreach (sb[q]) if (k < 0 && sb[q].core == int'(rsp_core)) k = q;
      chk("rsp_has_owner", (k >= 0), 1);
      if (k >= 0) begin
        chk("rsp_id", rsp_id, sb[k].id);
        chk("rsp_result", rsp_result, sb[k].res);
        occ[sb[k].core] = 1'b0;
        sb.delete(k);
      end
    end
    chk("core_busy", core_busy, occ);
    win = -1;
    if (occ != '1) begin
      for (int s = 0; s < NR; s++) begin
        int i;
        i = (rr + s) % NR;
        if (win < 0 && req_valid[i]) win = i;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (win >= 0) begin
      fc = -1;
      for (int c = NC - 1; c >= 0; c--) if (!occ[c]) fc = c;
      va = req_a[win*8 +: 8];
      vb = req_b[win*8 +: 8];
      vo = req_op[win*2 +: 2];
      sb.push_back('{id: win, core: fc, res: ref_alu(int'(va), int'(vb), int'(vo))});
      occ[fc] = 1'b1;
      rr = (win + 1) % NR;
    end
    prev_valid = rsp_valid;
    prev_ready = rsp_ready;
    prev_res   = rsp_result;
    prev_id    = rsp_id;
    prev_core  = rsp_core;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_valid[i]     = 1'b1;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic run_single(input int i, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] op, input int lat, input logic [15:0] exp_res,
                            input string tag);
    set_req(i, a, b, op);
    #1;
    chk({tag, "_ready"}, req_ready, 32'(1 << i));
    cyc();
    req_valid = '0;
    repeat (lat + 1) begin
      chk({tag, "_early_valid"}, rsp_valid, 0);
      cyc();
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_id"}, rsp_id, i);
    chk({tag, "_core"}, rsp_core, 0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int base;
    int issued;
    int guard;
    int exp_order[5];
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_core", rsp_core, 0);
    chk("rst_core_busy", core_busy, 0);

    // reset in the middle of a MUL
    set_req(0, 8'd200, 8'd200, 2'b10);
    cyc();
    chk("midmul_accept", acc_vec, 4'b0001);
    req_valid = '0;
    cyc();
    chk("midmul_busy_before", core_busy, 4'b0001);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midmul_core_busy", core_busy, 0);
    chk("midmul_rsp_valid", rsp_valid, 0);
    seen = 0;
    repeat (6) begin
      cyc();
      if (rsp_valid) seen++;
    end
    chk("midmul_no_rsp", seen, 0);

    // all requesters held valid: grants rotate from 0
    for (int i = 0; i < NR; i++) set_req(i, 8'(10 + i), 8'(20 + i), 2'b00);
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_grant", req_ready, 32'(1 << (g % NR)));
      cyc();
      for (int i = 0; i < NR; i++)
        if (acc_vec[i]) set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'b00);
    end
    req_valid = '0;
    repeat (6) cyc();

    run_single(0, 8'd255, 8'd1, 2'b00, 1, 16'h0100, "add");
    run_single(1, 8'd3, 8'd5, 2'b01, 1, 16'hFFFE, "sub");
    run_single(2, 8'd255, 8'd255, 2'b10, 3, 16'hFE01, "mul");

    // five MULs against a stalled consumer
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 8'(11 + i), 8'(7 + i), 2'b10);
    issued = 4;
    base   = dut_acc_cnt;
    rsp_cores.delete();
    guard  = 0;
    while ((dut_acc_cnt - base) < 4 && guard < 20) begin
      cyc();
      guard++;
      for (int i = 0; i < NR; i++) begin
        if (acc_vec[i]) begin
          if (issued < 5) begin
            set_req(i, 8'd99, 8'd3, 2'b10);
            issued++;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    chk("bp_four_accepted", dut_acc_cnt - base, 4);
    #1;
    chk("bp_core_busy_full", core_busy, 4'hF);
    chk("bp_req_ready_zero", req_ready, 0);
    repeat (10) begin
      cyc();
      req_valid = req_valid & ~acc_vec;
    end
    chk("bp_fifth_accepted", dut_acc_cnt - base, 5);
    chk("bp_held_valid", rsp_valid, 1);
    chk("bp_held_core", rsp_core, 0);
    rsp_ready = 1'b1;
    repeat (8) cyc();
    exp_order = '{0, 0, 1, 2, 3};
    chk("bp_drain_count", rsp_cores.size(), 5);
    for (int k = 0; k < 5 && k < rsp_cores.size(); k++)
      chk("bp_drain_order", rsp_cores[k], exp_order[k]);

    // MUL then ADD: ADD returns first; stall holds it
    set_req(0, 8'd12, 8'd13, 2'b10);
    cyc();
    chk("mix_mul_accept", acc_vec, 4'b0001);
    req_valid = '0;
    set_req(1, 8'd7, 8'd8, 2'b00);
    cyc();
    chk("mix_add_accept", acc_vec, 4'b0010);
    req_valid = '0;
    repeat (2) cyc();
    chk("mix_first_valid", rsp_valid, 1);
    chk("mix_first_id", rsp_id, 1);
    chk("mix_first_result", rsp_result, 16'd15);
    chk("mix_first_core", rsp_core, 1);
    rsp_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("mix_hold_valid", rsp_valid, 1);
      chk("mix_hold_id", rsp_id, 1);
      chk("mix_hold_result", rsp_result, 16'd15);
      chk("mix_hold_core", rsp_core, 1);
    end
    rsp_ready = 1'b1;
    cyc();
    chk("mix_second_valid", rsp_valid, 1);
    chk("mix_second_id", rsp_id, 0);
    chk("mix_second_result", rsp_result, 16'd156);
    chk("mix_second_core", rsp_core, 0);
    cyc();

    // randomized traffic with random consumer stalls
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
      req_valid = req_valid & ~acc_vec;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 60) begin
      cyc();
      guard++;
    end
    chk("rand_drain_empty", sb.size(), 0);
    repeat (2) cyc();
    chk("final_rsp_valid", rsp_valid, 0);
    chk("final_core_busy", core_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
